// File: rtl/kernel_2mm_unit.sv
// kernel_2mm_unit: PolyBench 2mm (tmp = alpha*A*B, then D = beta*D + tmp*C) on 32-bit wrapping integers,
// streaming operands from a shared dual-port word memory at one multiply-accumulate per cycle.
module kernel_2mm_unit #(
    parameter int N = 40
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ap_start,
    output logic        ap_done,
    output logic        ap_idle,
    output logic        ap_ready,
    output logic [13:0] indata_address0,
    output logic        indata_ce0,
    output logic        indata_we0,
    output logic [31:0] indata_d0,
    input  logic [31:0] indata_q0,
    output logic [13:0] indata_address1,
    output logic        indata_ce1,
    output logic        indata_we1,
    output logic [31:0] indata_d1,
    input  logic [31:0] indata_q1
);

    localparam int CW         = $clog2(N + 2);
    localparam int NN         = N * N;
    localparam int B_BASE     = NN;
    localparam int C_BASE     = 2 * NN;
    localparam int D_BASE     = 3 * NN;
    localparam int T_BASE     = 4 * NN;
    localparam int ALPHA_ADDR = 5 * NN;
    localparam int BETA_ADDR  = 5 * NN + 1;

    localparam logic [CW-1:0] ONE   = CW'(1);
    localparam logic [CW-1:0] K_TWO = CW'(2);
    localparam logic [CW-1:0] LAST  = CW'(N - 1);
    localparam logic [CW-1:0] K_N   = CW'(N);
    localparam logic [CW-1:0] K_N1  = CW'(N + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_SCALARS,
        S_PHASE1,
        S_PHASE2,
        S_DONE
    } state_t;

    state_t state, state_next;

    logic [CW-1:0] i, j, k;
    logic [31:0]   acc, alpha, beta;
    logic [31:0]   prod, acc_sum;
    logic [13:0]   ij_off, ik_off, kj_off;
    logic          last_elem, elem_end;

    // Operands requested in cycle k arrive in cycle k+1, so the MAC always lags the address counter by one.
    assign prod      = indata_q0 * indata_q1;
    assign acc_sum   = acc + prod;
    assign ij_off    = 14'(int'(i) * N + int'(j));
    assign ik_off    = 14'(int'(i) * N + int'(k));
    assign kj_off    = 14'(int'(k) * N + int'(j));
    assign last_elem = (i == LAST) && (j == LAST);
    assign elem_end  = ((state == S_PHASE1) && (k == K_N)) ||
                       ((state == S_PHASE2) && (k == K_N1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            i     <= '0;
            j     <= '0;
            k     <= '0;
            acc   <= '0;
            alpha <= '0;
            beta  <= '0;
        end else begin
            case (state)
                S_LOAD_SCALARS: begin
                    k <= (k == K_TWO) ? '0 : k + ONE;
                    if (k == ONE)   alpha <= indata_q1;
                    if (k == K_TWO) beta  <= indata_q1;
                end
                S_PHASE1, S_PHASE2: begin
                    if (elem_end) begin
                        k   <= '0;
                        acc <= '0;
                        if (j == LAST) begin
                            j <= '0;
                            i <= (i == LAST) ? '0 : i + ONE;
                        end else begin
                            j <= j + ONE;
                        end
                    end else begin
                        k <= k + ONE;
                        if (k != '0) acc <= acc_sum;
                    end
                end
                default: begin
                    i   <= '0;
                    j   <= '0;
                    k   <= '0;
                    acc <= '0;
                end
            endcase
        end
    end

    // Phase 1 element: N read cycles, then a write cycle that folds in the last product.
    // Phase 2 element: N read cycles, a D read while the last product lands, then the write.
    always_comb begin
        state_next      = state;
        ap_done         = 1'b0;
        ap_ready        = 1'b0;
        ap_idle         = (state == S_IDLE);
        indata_address0 = '0;
        indata_ce0      = 1'b0;
        indata_we0      = 1'b0;
        indata_d0       = '0;
        indata_address1 = '0;
        indata_ce1      = 1'b0;
        indata_we1      = 1'b0;
        indata_d1       = '0;
        case (state)
            S_IDLE: begin
                if (ap_start) state_next = S_LOAD_SCALARS;
            end
            S_LOAD_SCALARS: begin
                if (k == '0) begin
                    indata_ce1      = 1'b1;
                    indata_address1 = 14'(ALPHA_ADDR);
                end else if (k == ONE) begin
                    indata_ce1      = 1'b1;
                    indata_address1 = 14'(BETA_ADDR);
                end else begin
                    state_next = S_PHASE1;
                end
            end
            S_PHASE1: begin
                if (k == K_N) begin
                    indata_ce0      = 1'b1;
                    indata_we0      = 1'b1;
                    indata_address0 = 14'(T_BASE) + ij_off;
                    indata_d0       = alpha * acc_sum;
                    if (last_elem) state_next = S_PHASE2;
                end else begin
                    indata_ce0      = 1'b1;
                    indata_address0 = ik_off;
                    indata_ce1      = 1'b1;
                    indata_address1 = 14'(B_BASE) + kj_off;
                end
            end
            S_PHASE2: begin
                if (k == K_N1) begin
                    indata_ce0      = 1'b1;
                    indata_we0      = 1'b1;
                    indata_address0 = 14'(D_BASE) + ij_off;
                    indata_d0       = beta * indata_q0 + acc;
                    if (last_elem) state_next = S_DONE;
                end else if (k == K_N) begin
                    indata_ce0      = 1'b1;
                    indata_address0 = 14'(D_BASE) + ij_off;
                end else begin
                    indata_ce0      = 1'b1;
                    indata_address0 = 14'(T_BASE) + ik_off;
                    indata_ce1      = 1'b1;
                    indata_address1 = 14'(C_BASE) + kj_off;
                end
            end
            S_DONE: begin
                ap_done    = 1'b1;
                ap_ready   = 1'b1;
                state_next = ap_start ? S_LOAD_SCALARS : S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_kernel_2mm_unit.sv
// Testbench for kernel_2mm_unit at N=4: external dual-port memory model, protocol monitor and
// an arithmetic reference model of the 2mm kernel.
module tb_kernel_2mm_unit;

    localparam int N         = 4;
    localparam int NN        = N * N;
    localparam int B_BASE    = NN;
    localparam int C_BASE    = 2 * NN;
    localparam int D_BASE    = 3 * NN;
    localparam int T_BASE    = 4 * NN;
    localparam int MEM_WORDS = 5 * NN + 2;
    localparam int LAT_MAX   = 2 * NN * (N + 4) + 16;
    localparam int BUDGET    = 2000;

    logic        clk = 1'b0;
    logic        reset, ap_start, ap_done, ap_idle, ap_ready;
    logic [13:0] a0, a1;
    logic        ce0, ce1, we0, we1;
    logic [31:0] d0, d1;
    logic [31:0] q0 = '0, q1 = '0;

    logic        host_we = 1'b0;
    logic [13:0] host_addr = '0;
    logic [31:0] host_data = '0;

    logic [31:0] mem [0:16383];
    logic        r_ce0, r_we0, r_ce1, r_we1;
    logic [13:0] r_a0, r_a1;
    logic [31:0] r_d0, r_d1;

    logic [31:0] ma [NN], mb [NN], mc [NN], md [NN];
    logic [31:0] exp_tmp [NN], exp_d [NN];
    logic [31:0] alpha_v, beta_v;

    int n_checks = 0, n_pass = 0, n_fail = 0;
    int viol = 0, done_count = 0;
    logic last_dwrite = 1'b0, prev_done = 1'b0;

    always #5 clk = ~clk;

    kernel_2mm_unit #(.N(N)) dut (
        .clk(clk), .reset(reset), .ap_start(ap_start),
        .ap_done(ap_done), .ap_idle(ap_idle), .ap_ready(ap_ready),
        .indata_address0(a0), .indata_ce0(ce0), .indata_we0(we0), .indata_d0(d0), .indata_q0(q0),
        .indata_address1(a1), .indata_ce1(ce1), .indata_we1(we1), .indata_d1(d1), .indata_q1(q1)
    );

    // Requests are captured mid-cycle and serviced on the following rising edge with one-cycle read latency.
    always @(negedge clk) begin
        r_ce0 <= ce0; r_we0 <= we0; r_a0 <= a0; r_d0 <= d0;
        r_ce1 <= ce1; r_we1 <= we1; r_a1 <= a1; r_d1 <= d1;
    end

    always @(posedge clk) begin
        if (host_we) begin
            mem[host_addr] <= host_data;
        end else if (!reset) begin
            if (r_ce0) begin
                if (r_we0) mem[r_a0] <= r_d0;
                else       q0 <= mem[r_a0];
            end
            if (r_ce1) begin
                if (r_we1) mem[r_a1] <= r_d1;
                else       q1 <= mem[r_a1];
            end
        end
    end

    // Protocol monitor: tallies rule breaks, checked once at the end.
    always @(negedge clk) begin
        if ((reset || ap_idle) && (ce0 || ce1 || we0 || we1)) viol++;
        if (we1) viol++;
        if (ce0 && 32'(a0) >= MEM_WORDS) viol++;
        if (ce1 && 32'(a1) >= MEM_WORDS) viol++;
        if (ce0 && we0 && ce1 && a1 == a0) viol++;
        if (ap_done !== ap_ready) viol++;
        if (ap_done) begin
            done_count++;
            if (!last_dwrite || prev_done) viol++;
        end
        last_dwrite = ce0 && we0 && (a0 == 14'(D_BASE + NN - 1));
        prev_done   = ap_done;
    end

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic poke(input int addr, input logic [31:0] val);
        host_addr = 14'(addr);
        host_data = val;
        host_we   = 1'b1;
        @(negedge clk);
        host_we   = 1'b0;
    endtask

    // kind 0: identity/constant case, 1: all ones, 2: wrap case, 3: random
    task automatic fill_pattern(input int kind);
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                case (kind)
                    0: begin
                        ma[i*N+j] = (i == j) ? 32'd1 : 32'd0;
                        mb[i*N+j] = 32'd2;
                        mc[i*N+j] = (i == j) ? 32'd1 : 32'd0;
                        md[i*N+j] = 32'd5;
                    end
                    1: begin
                        ma[i*N+j] = 32'd1; mb[i*N+j] = 32'd1;
                        mc[i*N+j] = 32'd1; md[i*N+j] = 32'd1;
                    end
                    2: begin
                        ma[i*N+j] = (i == 0 && j == 0) ? 32'h7FFF_FFFF : 32'd0;
                        mb[i*N+j] = (i == 0 && j == 0) ? 32'd2 : 32'd0;
                        mc[i*N+j] = (i == j) ? 32'd1 : 32'd0;
                        md[i*N+j] = 32'd0;
                    end
                    default: begin
                        ma[i*N+j] = $urandom; mb[i*N+j] = $urandom;
                        mc[i*N+j] = $urandom; md[i*N+j] = $urandom;
                    end
                endcase
            end
        end
        case (kind)
            0:       begin alpha_v = 32'd3; beta_v = 32'd0; end
            1, 2:    begin alpha_v = 32'd1; beta_v = 32'd1; end
            default: begin alpha_v = $urandom; beta_v = $urandom; end
        endcase
    endtask

    task automatic apply_stimulus();
        for (int x = 0; x < NN; x++) begin
            poke(x, ma[x]);
            poke(B_BASE + x, mb[x]);
            poke(C_BASE + x, mc[x]);
            poke(D_BASE + x, md[x]);
            poke(T_BASE + x, 32'hDEAD_BEEF);
            exp_d[x] = md[x];
        end
        poke(5 * NN, alpha_v);
        poke(5 * NN + 1, beta_v);
    endtask

    // Reference: tmp = sum of alpha*A*B terms, D = beta*D + sum of tmp*C terms, all mod 2^32.
    task automatic model_run();
        logic [31:0] s;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                s = '0;
                for (int k = 0; k < N; k++) s = s + alpha_v * ma[i*N+k] * mb[k*N+j];
                exp_tmp[i*N+j] = s;
            end
        end
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                s = beta_v * exp_d[i*N+j];
                for (int k = 0; k < N; k++) s = s + exp_tmp[i*N+k] * mc[k*N+j];
                exp_d[i*N+j] = s;
            end
        end
    endtask

    task automatic compare_memory(input string name);
        for (int x = 0; x < NN; x++) begin
            check_output($sformatf("%s_tmp[%0d]", name, x), mem[T_BASE + x], exp_tmp[x]);
            check_output($sformatf("%s_d[%0d]", name, x), mem[D_BASE + x], exp_d[x]);
        end
    endtask

    task automatic wait_done(output logic ok, output int lat);
        ok  = 1'b0;
        lat = 0;
        while (!ok && lat < BUDGET) begin
            @(negedge clk);
            lat++;
            if (ap_done) ok = 1'b1;
        end
    endtask

    task automatic run_once(input string name);
        logic ok;
        int   lat;
        int   done0;
        done0    = done_count;
        ap_start = 1'b1;
        @(negedge clk);
        ap_start = 1'b0;
        check_output({name, "_idle_drop"}, 32'(ap_idle), 0);
        wait_done(ok, lat);
        check_output({name, "_done_seen"}, 32'(ok), 1);
        check_output({name, "_ready_with_done"}, 32'(ap_ready), 1);
        check_output({name, "_latency_ok"}, 32'(lat + 1 <= LAT_MAX), 1);
        @(negedge clk);
        check_output({name, "_idle_back"}, 32'(ap_idle), 1);
        check_output({name, "_done_pulses"}, 32'(done_count - done0), 1);
    endtask

    initial begin
        logic ok1, ok2;
        int   lat1, lat2, done0;

        reset    = 1'b1;
        ap_start = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check_output("rst_idle", 32'(ap_idle), 1);
            check_output("rst_done", 32'(ap_done), 0);
            check_output("rst_ready", 32'(ap_ready), 0);
            check_output("rst_ce_we", 32'({ce0, ce1, we0, we1}), 0);
        end
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check_output("idle_after_reset", 32'(ap_idle), 1);

        fill_pattern(0);
        apply_stimulus();
        run_once("ident");
        model_run();
        compare_memory("ident");
        check_output("ident_tmp_const", mem[T_BASE + 5], 32'd6);
        check_output("ident_d_const", mem[D_BASE + 5], 32'd6);

        fill_pattern(1);
        apply_stimulus();
        run_once("ones");
        model_run();
        compare_memory("ones");
        check_output("ones_d_const", mem[D_BASE], 32'd17);

        fill_pattern(2);
        apply_stimulus();
        run_once("wrap");
        model_run();
        compare_memory("wrap");
        check_output("wrap_d00", mem[D_BASE], 32'hFFFF_FFFE);

        for (int r = 0; r < 2; r++) begin
            fill_pattern(3);
            apply_stimulus();
            run_once($sformatf("rand%0d", r));
            model_run();
            compare_memory($sformatf("rand%0d", r));
        end

        fill_pattern(3);
        apply_stimulus();
        done0    = done_count;
        ap_start = 1'b1;
        @(negedge clk);
        wait_done(ok1, lat1);
        check_output("b2b_first_done", 32'(ok1), 1);
        @(negedge clk);
        check_output("b2b_restart_busy", 32'(ap_idle), 0);
        ap_start = 1'b0;
        wait_done(ok2, lat2);
        check_output("b2b_second_done", 32'(ok2), 1);
        repeat (10) @(negedge clk);
        check_output("b2b_done_pulses", 32'(done_count - done0), 2);
        model_run();
        model_run();
        compare_memory("b2b");

        fill_pattern(1);
        apply_stimulus();
        done0    = done_count;
        ap_start = 1'b1;
        @(negedge clk);
        ap_start = 1'b0;
        repeat (20) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check_output("midrst_ce_we", 32'({ce0, ce1, we0, we1}), 0);
        check_output("midrst_idle", 32'(ap_idle), 1);
        check_output("midrst_done", 32'(ap_done), 0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        check_output("midrst_no_done", 32'(done_count - done0), 0);
        fill_pattern(1);
        apply_stimulus();
        run_once("after_rst");
        model_run();
        compare_memory("after_rst");

        check_output("protocol_violations", 32'(viol), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/kernel_2mm_unit.md
# kernel_2mm_unit

Fixed-function accelerator computing the PolyBench "2mm" kernel on signed 32-bit integers: tmp = alpha·A·B, then D = beta·D + tmp·C. All operands and results live in one external 16384-word dual-port memory (`indata`) that the block drives through two independent ports. It sits behind the host read/write harness, which loads the memory, pulses start, waits for done and reads the memory back. Handshake follows the HLS ap_ctrl_hs convention.

## Interface
- `N`, default 40: square matrix dimension; must satisfy 5·N²+2 ≤ 16384.
- `clk` in 1: clock, all logic on rising edge.
- `reset` in 1: reset, asynchronous, active-high.
- `ap_start` in 1: start request, sampled while idle.
- `ap_done` out 1: one-cycle pulse at completion.
- `ap_idle` out 1: high when no run is active.
- `ap_ready` out 1: one-cycle pulse, same cycle as `ap_done`.
- `indata_address0` / `indata_address1` out 14: word address, ports 0/1.
- `indata_ce0` / `indata_ce1` out 1: access enable.
- `indata_we0` / `indata_we1` out 1: write enable, qualified by ce.
- `indata_d0` / `indata_d1` out 32: write data.
- `indata_q0` / `indata_q1` in 32: read data.

## Operation
- Memory map (word addresses, row-major, element [i][j] at base+i·N+j): A at 0, B at N², C at 2N², D at 3N², tmp at 4N², alpha at 5N², beta at 5N²+1. For N=40: A 0–1599, B 1600–3199, C 3200–4799, D 4800–6399, tmp 6400–7999, alpha 8000, beta 8001.
- Run sequence: read alpha and beta; phase 1, for all i,j: tmp[i][j] = Σk alpha·A[i][k]·B[k][j], written to the tmp region; phase 2 starts only after every tmp write is issued, for all i,j: D[i][j] = beta·D[i][j] + Σk tmp[i][k]·C[k][j], written back in place.
- Arithmetic: two's-complement 32-bit; every product and sum keeps the low 32 bits (wrap, no saturation).
- Port use: port 0 reads A/tmp and D and performs all writes; port 1 reads B/C/scalars. Both ports never write in the same cycle. A port never reads an address being written in the same cycle.
- Accesses stay within 0..5N²+1. No access (ce low) while idle.
- Control FSM: IDLE → (ap_start=1) LOAD_SCALARS → PHASE1 → PHASE2 → DONE → IDLE. `ap_start` in any non-IDLE state is ignored. If `ap_start` is high in the DONE cycle, the next run starts immediately; otherwise the FSM waits in IDLE.
- Output values while in reset: `ap_idle`=1; `ap_done`, `ap_ready`, ce0/1, we0/1 = 0; addresses and d0/d1 = 0.

## Timing
- Memory model: on an edge with ce=1, we=1 the word is written; on an edge with ce=1, we=0, q presents the addressed word from the next cycle and holds it until the next read on that port. Read latency is exactly 1 cycle; the block must pipeline to match.
- A single-cycle `ap_start` pulse must be accepted; `ap_idle` drops the cycle after start is sampled.
- `ap_done`/`ap_ready`: high for exactly one cycle, in the cycle after the last D write is issued; `ap_idle` returns high the next cycle.
- Throughput target: one multiply-accumulate per cycle per phase; total start-to-done latency ≤ 2·N²·(N+4)+16 cycles (≤ 140816 for N=40).
- Reset asserted mid-run: all ce/we drop asynchronously, FSM returns to IDLE, no `ap_done`; memory contents are partially updated and undefined.

## Test plan
- Reset: hold `reset` 3 cycles → `ap_idle`=1, `ap_done`=`ap_ready`=0, ce0/ce1/we0/we1=0 throughout; no memory access until `ap_start`.
- N=4, A=I, B all 2, alpha=3, C=I, beta=0, D all 5, one-cycle start → tmp all 6, D all 6; single `ap_done` pulse coincident with `ap_ready`.
- N=40 defaults, A=B=C=D all 1, alpha=beta=1 → tmp all 40, D all 1601; latency ≤ 140816 cycles; no access outside 0–8001.
- Wrap: N=4, alpha=1, A[0][0]=0x7FFFFFFF, B[0][0]=2, all other A/B zero, C=I, beta=1, D zero → tmp[0][0]=D[0][0]=0xFFFFFFFE; all others 0.
- `ap_start` held high for 2 runs on identical inputs (D reloaded by the bench between runs is not required; D accumulates) → second run starts the cycle after the first `ap_done`; exactly two `ap_done` pulses.
- Reset mid phase 1 → ce/we drop immediately, `ap_idle`=1, no `ap_done`; after bench reloads memory and restarts, results match the all-ones case.
